// File: rtl/poly_modq_to_s3_if.sv
// rtl/poly_modq_to_s3_if.sv - coefficient-in / trit-out stream bundle for poly_modq_to_s3
//
// Signals:
//   in_valid  in_coef is valid                 (master -> slave)
//   in_ready  slave accepts in_coef this cycle (slave -> master)
//   in_coef   Q_BITS-bit unsigned coefficient  (master -> slave)
//   out_valid out_trit is valid                (slave -> master)
//   out_ready master accepts out_trit          (master -> slave)
//   out_trit  2'b00=0, 2'b01=+1, 2'b10=-1      (slave -> master)
//   out_last  last trit of a polynomial        (slave -> master)
// Modports: master = coefficient source / trit sink; slave = the converter.
interface poly_modq_to_s3_if #(
  parameter int Q_BITS = 13
);
  logic              in_valid;
  logic              in_ready;
  logic [Q_BITS-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_trit;
  logic              out_last;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_trit, out_last
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_trit, out_last
  );
endinterface

// File: rtl/poly_modq_to_s3.sv
// rtl/poly_modq_to_s3.sv - centers mod-q coefficients into [-q/2, q/2) and reduces them mod 3
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   poly_modq_to_s3_if.slave: in_valid/in_ready/in_coef stream in,
//         out_valid/out_ready/out_trit/out_last stream out
//   busy  at least one coefficient is held inside the block
// Parameters: N coefficients per polynomial, Q_BITS coefficient width,
//   CNT_W index counter width (2**CNT_W >= N).
// Build option: PHI_REDUCE_EN selects store-and-forward reduction mod (3, Phi_N),
//   emitting (t[i] - t[N-1]) mod 3; without it the block is a 2-stage stream.
module poly_modq_to_s3 #(
  parameter int N      = 701,
  parameter int Q_BITS = 13,
  parameter int CNT_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  poly_modq_to_s3_if.slave       bus,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  // x mod 3 without a divider: 2^even = 1 and 2^odd = 2 (mod 3), so weighting the
  // bits gives a small partial residue; base-4 digit sums then fold it down.
  function automatic logic [1:0] mod3(input logic [Q_BITS-1:0] x);
    logic [7:0] s;
    logic [3:0] s2;
    logic [2:0] s3;
    s = '0;
    for (int i = 0; i < Q_BITS; i++) begin
      if (x[i]) s = s + (((i % 2) == 0) ? 8'd1 : 8'd2);
    end
    s2 = {2'b00, s[1:0]} + {2'b00, s[3:2]} + {2'b00, s[5:4]} + {2'b00, s[7:6]};
    s3 = {1'b0, s2[1:0]} + {1'b0, s2[3:2]};
    if (s3 >= 3'd6)      s3 = s3 - 3'd6;
    else if (s3 >= 3'd3) s3 = s3 - 3'd3;
    return s3[1:0];
  endfunction

  // Centering subtracts q, and q = 2 (mod 3), so the residue gains +1.
  function automatic logic [1:0] center_adj(input logic [1:0] r, input logic hi);
    if (!hi) return r;
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

`ifdef PHI_REDUCE_EN

  function automatic logic [1:0] sub3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] d;
    d = {1'b0, a} + 3'd3 - {1'b0, b};
    if (d >= 3'd3) d = d - 3'd3;
    return d[1:0];
  endfunction

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state;
  logic [1:0]       trit_mem [N];
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       t_last;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       out_trit_r;
  logic             out_last_r;
  logic [1:0]       t_in;
  logic             in_fire;

  assign t_in    = center_adj(mod3(bus.in_coef), bus.in_coef[Q_BITS-1]);
  assign in_fire = bus.in_valid & in_ready_r;

  // Trit buffer carries no reset: every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) trit_mem[load_cnt] <= t_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD;
      load_cnt    <= '0;
      rd_cnt      <= '0;
      t_last      <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_trit_r  <= 2'd0;
      out_last_r  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (load_cnt == LAST_IDX) begin
              state      <= DRAIN;
              in_ready_r <= 1'b0;
              load_cnt   <= '0;
              t_last     <= t_in;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Output register is (re)loaded on entry and after each non-final transfer.
          if (!out_valid_r || (bus.out_ready && !out_last_r)) begin
            out_valid_r <= 1'b1;
            out_trit_r  <= sub3(trit_mem[rd_cnt], t_last);
            out_last_r  <= (rd_cnt == LAST_IDX);
            rd_cnt      <= rd_cnt + 1'b1;
          end else if (bus.out_ready) begin
            state       <= LOAD;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            rd_cnt      <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_trit  = out_trit_r;
  assign bus.out_last  = out_last_r;
  assign busy          = (state != LOAD) | (load_cnt != '0);

`else

  logic             s1_valid;
  logic [1:0]       s1_r;
  logic             s1_hi;
  logic             s2_valid;
  logic [1:0]       s2_t;
  logic [CNT_W-1:0] out_cnt;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  assign s1_adv   = s1_valid & (~s2_valid | bus.out_ready);
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = s2_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_r     <= 2'd0;
      s1_hi    <= 1'b0;
      s2_valid <= 1'b0;
      s2_t     <= 2'd0;
      out_cnt  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_r     <= mod3(bus.in_coef);
        s1_hi    <= bus.in_coef[Q_BITS-1];
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_t     <= center_adj(s1_r, s1_hi);
      end else if (out_fire) begin
        s2_valid <= 1'b0;
      end

      if (out_fire) out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = ~s1_valid | s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_trit  = s2_t;
  assign bus.out_last  = s2_valid & (out_cnt == LAST_IDX);
  assign busy          = s1_valid | s2_valid;

`endif

endmodule

// File: tb/tb_poly_modq_to_s3.sv
// tb/tb_poly_modq_to_s3.sv - directed and model-checked bench for poly_modq_to_s3 (N=5)
module tb_poly_modq_to_s3;
  localparam int N  = 5;
  localparam int QB = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  poly_modq_to_s3_if #(.Q_BITS(QB)) bus ();

  poly_modq_to_s3 #(.N(N), .Q_BITS(QB), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;
  int saw_in_stall = 0;
  logic [QB-1:0] stim [0:255];
  logic [1:0]    expv [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed centered value, then a true mod 3 mapped to the trit code.
  function automatic logic [1:0] model_t(input logic [QB-1:0] x);
    int c;
    c = int'(x);
    if (c >= 4096) c = c - 8192;
    c = ((c % 3) + 3) % 3;
    return 2'(c);
  endfunction

  function automatic logic [1:0] model_sub(input logic [1:0] a, input logic [1:0] b);
    int d;
    d = (int'(a) - int'(b) + 3) % 3;
    return 2'(d);
  endfunction

  task automatic fill_exp(input int n);
    for (int i = 0; i < n; i++) begin
`ifdef PHI_REDUCE_EN
      expv[i] = model_sub(model_t(stim[i]), model_t(stim[(i / N) * N + N - 1]));
`else
      expv[i] = model_t(stim[i]);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; mode 1: out_ready low for cycles [lo,hi); mode 2: random gaps.
  task automatic run(input int n, input int mode, input int lo, input int hi);
    int in_i;
    int out_i;
    int cyc;
    in_i = 0;
    out_i = 0;
    cyc = 0;
    while (out_i < n && cyc < 3000) begin
      bus.in_valid  = (in_i < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      bus.in_coef   = (in_i < n) ? stim[in_i] : '0;
      bus.out_ready = (mode == 1) ? !(cyc >= lo && cyc < hi) :
                      (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (bus.in_valid && !bus.in_ready) saw_in_stall++;
`ifdef PHI_REDUCE_EN
      if (bus.out_valid) check("drain_in_ready", 32'(bus.in_ready), 32'(0));
`endif
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("trit[%0d]", out_i), 32'(bus.out_trit), 32'(expv[out_i]));
        check($sformatf("last[%0d]", out_i), 32'(bus.out_last), 32'((out_i % N) == N - 1));
        out_i++;
      end
      if (bus.in_valid && bus.in_ready) in_i++;
      tick();
      cyc++;
    end
    check("run_complete", 32'(out_i), 32'(n));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    check({tag, "_out_trit"},  32'(bus.out_trit),  32'(0));
    check({tag, "_out_last"},  32'(bus.out_last),  32'(0));
    check({tag, "_busy"},      32'(busy),          32'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check("in_ready_after_reset", 32'(bus.in_ready), 32'(1));

`ifndef PHI_REDUCE_EN
    // Latency: a coefficient presented in cycle 0 shows up as out_valid in cycle 2.
    bus.in_valid = 1'b1;
    bus.in_coef  = 13'd1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'(0));
    check("lat_cycle1_busy",  32'(busy),          32'(1));
    tick();
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'(1));
    check("lat_cycle2_trit",  32'(bus.out_trit),  32'(2'b01));
    tick();
    check("lat_drained_valid", 32'(bus.out_valid), 32'(0));
    check("lat_drained_busy",  32'(busy),          32'(0));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif

    // Directed vector 1, 8191, 4096, 4095, 5 with hand-computed results.
    stim[0] = 13'd1;    stim[1] = 13'd8191; stim[2] = 13'd4096;
    stim[3] = 13'd4095; stim[4] = 13'd5;
`ifdef PHI_REDUCE_EN
    expv[0] = 2'b10; expv[1] = 2'b00; expv[2] = 2'b00; expv[3] = 2'b01; expv[4] = 2'b00;
`else
    expv[0] = 2'b01; expv[1] = 2'b10; expv[2] = 2'b10; expv[3] = 2'b00; expv[4] = 2'b10;
`endif
    run(5, 0, 0, 0);

`ifdef PHI_REDUCE_EN
    // t = 01,10,00,10,01 -> outputs relative to t[N-1]=01.
    stim[0] = 13'd1; stim[1] = 13'd2; stim[2] = 13'd0; stim[3] = 13'd8191; stim[4] = 13'd1;
    expv[0] = 2'b00; expv[1] = 2'b01; expv[2] = 2'b10; expv[3] = 2'b01; expv[4] = 2'b00;
    run(5, 0, 0, 0);
`endif

    // Two polynomials back to back: out_last on transfers 5 and 10.
    stim[0] = 13'd2;    stim[1] = 13'd3;    stim[2] = 13'd4097; stim[3] = 13'd8190;
    stim[4] = 13'd6000; stim[5] = 13'd100;  stim[6] = 13'd7;    stim[7] = 13'd4094;
    stim[8] = 13'd4098; stim[9] = 13'd12;
    fill_exp(10);
    run(10, 0, 0, 0);

    // Output stall of 5 cycles mid-stream: input must back-pressure, order preserved.
    for (int i = 0; i < 10; i++) stim[i] = 13'(i * 811 + 37);
    fill_exp(10);
    saw_in_stall = 0;
    run(10, 1, 3, 8);
    check("stall_in_ready_dropped", 32'(saw_in_stall > 0), 32'(1));

    // Reset after 3 of 5 inputs discards them; the next 5 form a fresh polynomial.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_coef  = 13'(1000 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_reset_outputs("midpoly_reset");
    rst = 1'b1;
    tick();
    check("midpoly_in_ready", 32'(bus.in_ready), 32'(1));
    stim[0] = 13'd8000; stim[1] = 13'd4; stim[2] = 13'd4096; stim[3] = 13'd11; stim[4] = 13'd2222;
    fill_exp(5);
    run(5, 0, 0, 0);

    // Random coefficients with random valid/ready gaps against the model.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 50; i++) stim[i] = 13'($urandom_range(0, 8191));
      fill_exp(50);
      run(50, 2, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
